// File: rtl/rr_arbiter_bin_pkg.sv
// rtl/rr_arbiter_bin_pkg.sv - arb_pkg: FSM state type and modulo pointer increment
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Advance a rotating pointer by one, wrapping at num (not at a power of two)
    function automatic int ptr_inc(input int p, input int num);
        return (p + 1 >= num) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_bin_if.sv
// rtl/rr_arbiter_bin_if.sv - request/grant bundle; lock_i exists only with ARB_LOCK_EN
interface rr_arbiter_bin_if #(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = 4
);
    logic [NUM_REQ-1:0] req_i;
    logic               gnt_valid_o;
    logic               gnt_ready_i;
    logic [IDX_W-1:0]   gnt_idx_o;
    logic [IDX_W-1:0]   ptr_o;
`ifdef ARB_LOCK_EN
    logic               lock_i;

    modport master (
        input  req_i, gnt_ready_i, lock_i,
        output gnt_valid_o, gnt_idx_o, ptr_o
    );

    modport slave (
        output req_i, gnt_ready_i, lock_i,
        input  gnt_valid_o, gnt_idx_o, ptr_o
    );
`else
    modport master (
        input  req_i, gnt_ready_i,
        output gnt_valid_o, gnt_idx_o, ptr_o
    );

    modport slave (
        output req_i, gnt_ready_i,
        input  gnt_valid_o, gnt_idx_o, ptr_o
    );
`endif
endinterface

// File: rtl/rr_arbiter_bin_pick.sv
// rtl/rr_arbiter_bin_pick.sv - rr_pick: combinational rotating-priority encoder
module rr_pick #(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               any_o,
    output logic [IDX_W-1:0]   idx_o
);
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] sel;

    // Lowest set bit at or above ptr, else lowest set bit overall (the wrap)
    always_comb begin
        mask   = ~((NUM_REQ'(1) << ptr_i) - NUM_REQ'(1));
        masked = req_i & mask;
        sel    = (|masked) ? masked : req_i;
        any_o  = |req_i;
        idx_o  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (sel[k]) begin
                idx_o = IDX_W'(k);
            end
        end
    end
endmodule

// File: rtl/rr_arbiter_bin.sv
// rtl/rr_arbiter_bin.sv - round-robin arbiter with registered binary grant; optional ARB_LOCK_EN
module rr_arbiter_bin
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = 4
) (
    input  logic           clk,
    input  logic           reset,
    rr_arbiter_bin_if.master bus
);
    if (IDX_W != $clog2(NUM_REQ) || NUM_REQ < 2) begin : g_bad_param
        $error("rr_arbiter_bin: IDX_W must equal $clog2(NUM_REQ) and NUM_REQ >= 2");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             hs;
    logic             relock;
    logic             hold_ptr;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i (bus.req_i),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    assign hs = (state_q == GRANT) && bus.gnt_ready_i;

`ifdef ARB_LOCK_EN
    logic lock_q, lock_d;

    // Lock flag remembers that the last grant asked to keep its slot
    always_ff @(posedge clk) begin
        if (reset) lock_q <= 1'b0;
        else       lock_q <= lock_d;
    end

    // Flag follows lock_i on every handshake and is otherwise held
    always_comb begin
        lock_d = hs ? bus.lock_i : lock_q;
    end

    assign relock   = lock_q && bus.req_i[idx_q];
    assign hold_ptr = bus.lock_i;
`else
    assign relock   = 1'b0;
    assign hold_ptr = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: arbitrate in IDLE, wait for the handshake in GRANT
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = GRANT;
            GRANT:   if (hs)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next grant index and pointer; index only changes when a new grant is issued
    always_comb begin
        idx_d = idx_q;
        ptr_d = ptr_q;
        if (state_q == IDLE && pick_any) begin
            idx_d = relock ? idx_q : pick_idx;
        end
        if (hs && !hold_ptr) begin
            ptr_d = IDX_W'(ptr_inc(int'(idx_q), NUM_REQ));
        end
    end

    assign bus.gnt_valid_o = (state_q == GRANT);
    assign bus.gnt_idx_o   = idx_q;
    assign bus.ptr_o       = ptr_q;
endmodule

// File: tb/tb_rr_arbiter_bin.sv
// tb/tb_rr_arbiter_bin.sv - directed self-checking bench for rr_arbiter_bin (16- and 5-requester builds)
module tb_rr_arbiter_bin;
    logic clk = 1'b0;
    logic reset;
    int   assertions = 0;
    int   failures   = 0;

    always #5 clk = ~clk;

    rr_arbiter_bin_if #(.NUM_REQ(16), .IDX_W(4)) bus ();
    rr_arbiter_bin_if #(.NUM_REQ(5),  .IDX_W(3)) bus5 ();

    rr_arbiter_bin #(.NUM_REQ(16), .IDX_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rr_arbiter_bin #(.NUM_REQ(5), .IDX_W(3)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string tag, input logic v, input logic [3:0] idx, input logic [3:0] ptr);
        check({tag, ".valid"}, 32'(bus.gnt_valid_o), 32'(v));
        check({tag, ".idx"},   32'(bus.gnt_idx_o),   32'(idx));
        check({tag, ".ptr"},   32'(bus.ptr_o),       32'(ptr));
    endtask

    task automatic chk5(input string tag, input logic v, input logic [2:0] idx, input logic [2:0] ptr);
        check({tag, ".valid"}, 32'(bus5.gnt_valid_o), 32'(v));
        check({tag, ".idx"},   32'(bus5.gnt_idx_o),   32'(idx));
        check({tag, ".ptr"},   32'(bus5.ptr_o),       32'(ptr));
    endtask

    initial begin
        reset            = 1'b1;
        bus.req_i        = '0;
        bus.gnt_ready_i  = 1'b0;
        bus5.req_i       = '0;
        bus5.gnt_ready_i = 1'b0;
`ifdef ARB_LOCK_EN
        bus.lock_i       = 1'b0;
        bus5.lock_i      = 1'b0;
`endif
        // reset held two cycles, then idle with no requests
        tick();
        tick();
        chk16("reset", 1'b0, 4'd0, 4'd0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk16("idle", 1'b0, 4'd0, 4'd0);
        end

        // full rotation 0..15 then back to 0, one grant every two cycles
        bus.req_i       = 16'hFFFF;
        bus.gnt_ready_i = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            tick();
            chk16("rot_grant", 1'b1, 4'(i % 16), 4'(i % 16));
            tick();
            chk16("rot_bubble", 1'b0, 4'(i % 16), 4'((i + 1) % 16));
        end
        // ptr is now 1

        // backpressure: grant 4 held for 6 cycles even after req drops
        bus.req_i       = 16'h0010;
        bus.gnt_ready_i = 1'b0;
        tick();
        chk16("bp_grant", 1'b1, 4'd4, 4'd1);
        for (int c = 0; c < 6; c++) begin
            if (c == 3) bus.req_i = 16'h0000;
            tick();
            chk16("bp_hold", 1'b1, 4'd4, 4'd1);
        end
        bus.gnt_ready_i = 1'b1;
        tick();
        chk16("bp_accept", 1'b0, 4'd4, 4'd5);
        tick();
        chk16("bp_after", 1'b0, 4'd4, 4'd5);

        // fairness skip from ptr=5 with requesters 0 and 3
        bus.req_i = 16'h0009;
        tick(); chk16("fair_g0", 1'b1, 4'd0, 4'd5);
        tick(); chk16("fair_b0", 1'b0, 4'd0, 4'd1);
        tick(); chk16("fair_g3", 1'b1, 4'd3, 4'd1);
        tick(); chk16("fair_b3", 1'b0, 4'd3, 4'd4);
        tick(); chk16("fair_g0b", 1'b1, 4'd0, 4'd4);
        tick(); chk16("fair_b0b", 1'b0, 4'd0, 4'd1);

        // single requester regranted every two cycles
        bus.req_i = 16'h0100;
        tick(); chk16("single_g1", 1'b1, 4'd8, 4'd1);
        tick(); chk16("single_b1", 1'b0, 4'd8, 4'd9);
        tick(); chk16("single_g2", 1'b1, 4'd8, 4'd9);
        tick(); chk16("single_b2", 1'b0, 4'd8, 4'd9);

        // reset during a pending grant drops it without handshake
        bus.req_i       = 16'h0080;
        bus.gnt_ready_i = 1'b0;
        tick();
        chk16("mid_grant", 1'b1, 4'd7, 4'd9);
        reset = 1'b1;
        tick();
        chk16("mid_reset", 1'b0, 4'd0, 4'd0);
        chk5("mid_reset5", 1'b0, 3'd0, 3'd0);
        reset     = 1'b0;
        bus.req_i = 16'h0000;
        tick();
        chk16("post_reset", 1'b0, 4'd0, 4'd0);

        // NUM_REQ=5: move ptr to 4, then grant 4 and wrap ptr to 0 (not 8)
        bus5.gnt_ready_i = 1'b1;
        bus5.req_i       = 5'b01000;
        tick(); chk5("n5_g3", 1'b1, 3'd3, 3'd0);
        tick(); chk5("n5_b3", 1'b0, 3'd3, 3'd4);
        bus5.req_i = 5'b10001;
        tick(); chk5("n5_g4", 1'b1, 3'd4, 3'd4);
        tick(); chk5("n5_wrap", 1'b0, 3'd4, 3'd0);
        tick(); chk5("n5_g0", 1'b1, 3'd0, 3'd0);
        tick(); chk5("n5_b0", 1'b0, 3'd0, 3'd1);
        bus5.req_i = '0;

`ifdef ARB_LOCK_EN
        // lock keeps the slot: grant 1 twice, then rotation resumes to 2
        tick();
        bus.req_i       = 16'h0006;
        bus.gnt_ready_i = 1'b1;
        bus.lock_i      = 1'b1;
        tick(); chk16("lock_g1", 1'b1, 4'd1, 4'd0);
        tick(); chk16("lock_b1", 1'b0, 4'd1, 4'd0);
        bus.lock_i = 1'b0;
        tick(); chk16("lock_g1b", 1'b1, 4'd1, 4'd0);
        tick(); chk16("lock_b1b", 1'b0, 4'd1, 4'd2);
        tick(); chk16("lock_g2", 1'b1, 4'd2, 4'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
